// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: parity modes, FSM states
// and bit-timing helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_e;

    function automatic int calc_symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int calc_sample(input int clock_freq, input int baud_rate);
        return calc_symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is
// accepted only when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    // Head is forced to zero while empty so the outputs read 0 out of reset.
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver_ext.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote, false-start
// and break handling, parity/framing flags, receive FIFO with sticky overrun.
module uart_receiver_ext
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 overrun,
    input  logic                 overrun_clear
);
    localparam int SET    = calc_symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE = calc_sample(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = $clog2(SET);
    localparam int BW     = $clog2(DATA_BITS + 1);
    localparam int FW     = DATA_BITS + 2;

    logic rx_meta, rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    rx_state_e            state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp0, smp1, perr, stop_bad, stop_idx;
    logic                 maj, decide, sym_edge, last_stop, ferr, push, pop;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_dout;

    // The third vote is the live sample, so the decision lands at SAMPLE+1.
    assign maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign decide    = (cnt == CW'(SAMPLE + 1));
    assign sym_edge  = (cnt == CW'(SET - 1));
    assign last_stop = (state == S_STOP) && decide && ((STOP_BITS == 1) || stop_idx);
    assign ferr      = !maj || stop_bad;
    assign push      = last_stop;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nxt = S_START;
            S_START: begin
                if (decide && maj) state_nxt = S_IDLE;
                else if (sym_edge) state_nxt = S_DATA;
            end
            S_DATA:   if (sym_edge && bit_cnt == BW'(DATA_BITS))
                          state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (sym_edge) state_nxt = S_STOP;
            S_STOP:   if (last_stop) state_nxt = ferr ? S_BREAK : S_IDLE;
            S_BREAK:  if (rx_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            perr     <= 1'b0;
            stop_bad <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || state == S_BREAK || sym_edge) cnt <= '0;
            else                                                 cnt <= cnt + 1'b1;
            if (cnt == CW'(SAMPLE - 1)) smp0 <= rx_s;
            if (cnt == CW'(SAMPLE))     smp1 <= rx_s;
            if (state == S_IDLE) begin
                bit_cnt  <= '0;
                perr     <= 1'b0;
                stop_bad <= 1'b0;
                stop_idx <= 1'b0;
            end
            if (state == S_DATA && decide) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_PARITY && decide)
                perr <= ((^shreg) ^ maj) != (PARITY == PAR_ODD);
            if (state == S_STOP && decide)   stop_bad <= !maj;
            if (state == S_STOP && sym_edge) stop_idx <= 1'b1;
        end
    end

    assign pop            = data_out_valid && data_out_ready;
    assign data_out_valid = !fifo_empty;
    assign {frame_err, parity_err, data_out} = fifo_dout;

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push),
        .din   ({ferr, perr, shreg}),
        .full  (fifo_full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset)                          overrun <= 1'b0;
        else if (push && fifo_full && !pop) overrun <= 1'b1;
        else if (overrun_clear)             overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_receiver_ext.sv
// Bench for uart_receiver_ext: an 8N1 instance and a 7E2 instance at 32 clocks
// per bit, table vectors, corner-case sequences and a random scoreboard run.
module tb_uart_receiver_ext;

    localparam int SET        = 32;
    localparam int SAMPLE     = SET / 2;
    localparam int POP_BUDGET = 20 * SET;
    localparam int NR         = 12;

    logic       clk, reset;
    logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
    logic [7:0] data_a;
    logic       perr_a, ferr_a, valid_a, ovr_a;
    logic [6:0] data_b;
    logic       perr_b, ferr_b, valid_b, ovr_b;

    int checks = 0;
    int errors = 0;

    uart_receiver_ext #(
        .CLOCK_FREQ(32_000_000), .BAUD_RATE(1_000_000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .serial_in(rx_a),
        .data_out(data_a), .parity_err(perr_a), .frame_err(ferr_a),
        .data_out_valid(valid_a), .data_out_ready(ready_a),
        .overrun(ovr_a), .overrun_clear(clr_a)
    );

    uart_receiver_ext #(
        .CLOCK_FREQ(32_000_000), .BAUD_RATE(1_000_000),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .serial_in(rx_b),
        .data_out(data_b), .parity_err(perr_b), .frame_err(ferr_b),
        .data_out_valid(valid_b), .data_out_ready(ready_b),
        .overrun(ovr_b), .overrun_clear(clr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [6:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) rx_a = v;
        else           rx_b = v;
    endtask

    // bits[0] is the start bit; the line returns high for two bit times after.
    task automatic send_frame(input int line, input logic [15:0] bits, input int n, input int glitch_idx);
        logic lv;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < SET; c++) begin
                @(negedge clk);
                lv = bits[b];
                if (b == glitch_idx && c == SAMPLE) lv = ~lv;
                drive(line, lv);
            end
        end
        for (int c = 0; c < 2 * SET; c++) begin
            @(negedge clk);
            drive(line, 1'b1);
        end
    endtask

    task automatic pop_entry(input int line, output logic [31:0] e, output bit ok);
        ok = 1'b0;
        e  = '0;
        for (int i = 0; i < POP_BUDGET; i++) begin
            @(negedge clk);
            if ((line == 0) ? valid_a : valid_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (line == 0) begin
                e = {22'b0, ferr_a, perr_a, data_a};
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end else begin
                e = {23'b0, ferr_b, perr_b, data_b};
                ready_b = 1'b1;
                @(negedge clk);
                ready_b = 1'b0;
            end
        end
    endtask

    task automatic expect_entry(input string name, input int line, input logic [31:0] exp);
        logic [31:0] e;
        bit ok;
        pop_entry(line, e, ok);
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
        else     check(name, e, exp);
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    initial begin
        logic [15:0] bits;
        bit          seen;

        // {data, parity bit, stop bits, expected data, parity_err, frame_err}, even parity
        vecs[0] = '{7'h07, 1'b0, 2'b11, 7'h07, 1'b1, 1'b0};
        vecs[1] = '{7'h07, 1'b1, 2'b11, 7'h07, 1'b0, 1'b0};
        vecs[2] = '{7'h00, 1'b0, 2'b11, 7'h00, 1'b0, 1'b0};
        vecs[3] = '{7'h7F, 1'b1, 2'b11, 7'h7F, 1'b0, 1'b0};
        vecs[4] = '{7'h55, 1'b1, 2'b11, 7'h55, 1'b1, 1'b0};
        vecs[5] = '{7'h2A, 1'b1, 2'b00, 7'h2A, 1'b0, 1'b1};
        vecs[6] = '{7'h11, 1'b0, 2'b11, 7'h11, 1'b0, 1'b0};

        rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_valid_a", {31'b0, valid_a}, 32'd0);
        check("reset_data_a",  {24'b0, data_a}, 32'd0);
        check("reset_perr_a",  {31'b0, perr_a}, 32'd0);
        check("reset_ferr_a",  {31'b0, ferr_a}, 32'd0);
        check("reset_ovr_a",   {31'b0, ovr_a}, 32'd0);
        check("reset_valid_b", {31'b0, valid_b}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 7E2 table
        for (int i = 0; i < 7; i++) begin
            bits = {5'b0, vecs[i].stops, vecs[i].pbit, vecs[i].data, 1'b0};
            send_frame(1, bits, 11, -1);
            expect_entry($sformatf("tbl_entry%0d", i), 1,
                         {23'b0, vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_data});
            check($sformatf("tbl_empty%0d", i), {31'b0, valid_b}, 32'd0);
        end

        // 0xA5 with a one-cycle high glitch mid data bit 1 (a 0 bit)
        send_frame(0, frame_a(8'hA5, 1'b1), 10, 2);
        expect_entry("glitch_a5", 0, 32'h0A5);
        check("glitch_single", {31'b0, valid_a}, 32'd0);

        // short low pulse: false start
        for (int c = 0; c < 5; c++) begin @(negedge clk); rx_a = 1'b0; end
        seen = 1'b0;
        for (int c = 0; c < 3 * SET; c++) begin
            @(negedge clk);
            rx_a = 1'b1;
            if (valid_a) seen = 1'b1;
        end
        check("false_start_nopush", {31'b0, seen}, 32'd0);

        // held low for 20 bit times -> one break entry, then a normal frame
        for (int c = 0; c < 20 * SET; c++) begin @(negedge clk); rx_a = 1'b0; end
        for (int c = 0; c < 2 * SET; c++) begin @(negedge clk); rx_a = 1'b1; end
        send_frame(0, frame_a(8'h3C, 1'b1), 10, -1);
        expect_entry("break_entry", 0, 32'h200);
        expect_entry("after_break", 0, 32'h03C);
        check("break_only_two", {31'b0, valid_a}, 32'd0);

        // overrun: five frames into a four-deep FIFO with no consumer
        for (int k = 1; k <= 5; k++) send_frame(0, frame_a(8'(k), 1'b1), 10, -1);
        repeat (3) @(negedge clk);
        check("ovr_set", {31'b0, ovr_a}, 32'd1);
        check("ovr_head_held", {24'b0, data_a}, 32'h01);
        for (int k = 1; k <= 4; k++) expect_entry($sformatf("ovr_pop%0d", k), 0, 32'(k));
        check("ovr_drop5", {31'b0, valid_a}, 32'd0);
        check("ovr_sticky", {31'b0, ovr_a}, 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("ovr_cleared", {31'b0, ovr_a}, 32'd0);

        // reset in the middle of data bit 3 of 0xFF
        for (int c = 0; c < SET; c++) begin @(negedge clk); rx_a = 1'b0; end
        for (int c = 0; c < 3 * SET + SET / 2; c++) begin @(negedge clk); rx_a = 1'b1; end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midreset_valid", {31'b0, valid_a}, 32'd0);
        repeat (2 * SET) @(negedge clk);
        send_frame(0, frame_a(8'h5A, 1'b1), 10, -1);
        expect_entry("midreset_5a", 0, 32'h05A);
        check("midreset_only", {31'b0, valid_a}, 32'd0);
        check("midreset_ovr", {31'b0, ovr_a}, 32'd0);

        // random frames on 8N1 against a queue of expected entries, random consumer
        fork
            begin
                logic [7:0] d;
                logic       bad;
                for (int k = 0; k < NR; k++) begin
                    d   = 8'($urandom);
                    bad = ($urandom % 4) == 0;
                    exp_q.push_back({22'b0, bad, 1'b0, d});
                    send_frame(0, frame_a(d, !bad), 10, -1);
                end
            end
            begin
                int          got;
                int          cyc;
                logic        r;
                logic [31:0] e;
                got = 0;
                cyc = 0;
                while (got < NR && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom % 2);
                    if (r && valid_a) begin
                        if (exp_q.size() == 0) begin
                            check("rand_extra", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("rand_entry%0d", got), {22'b0, ferr_a, perr_a, data_a}, e);
                        end
                        got++;
                    end
                    ready_a = r;
                end
                @(negedge clk);
                ready_a = 1'b0;
                if (got < NR) check("rand_timeout", 32'(got), 32'(NR));
            end
        join
        check("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
